// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM state type and data-SRAM geometry for sram_ctrl
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } sram_state_e;

   localparam int unsigned SRAM_WORDS    = 64;
   localparam int unsigned SRAM_AW       = 6;
   localparam logic [31:0] DATA_SEG_BASE = 32'd1024;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - multi-cycle MEM-stage to data-SRAM access controller with pipeline-freeze ready
// Optional range checking with addr_err output is enabled by defining SRAM_CTRL_RANGE_CHECK_EN.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 4,
   parameter logic [31:0] BASE_ADDR   = DATA_SEG_BASE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 W_EN,
   input  logic                 R_EN,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [31:0]          read_data,
   output logic                 ready,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic                 sram_w_en,
   output logic                 sram_r_en,
   output logic [31:0]          sram_wdata,
   input  logic [31:0]          sram_rdata
`ifdef SRAM_CTRL_RANGE_CHECK_EN
   ,
   output logic                 addr_err
`endif
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   sram_state_e        state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               w_en_q, w_en_d;
   logic               r_en_q, r_en_d;
   logic               err_q, err_d;
   logic               req;
   logic               bad_req;
   logic [SRAM_AW-1:0] word_idx;

   assign req      = W_EN | R_EN;
   // 32-bit subtraction first so addresses below the base wrap into the top of the index range
   assign word_idx = SRAM_AW'((address - BASE_ADDR) >> 2);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
   assign bad_req  = (address < BASE_ADDR) || (address >= BASE_ADDR + 32'd256) ||
                     (address[1:0] != 2'b00);
   assign addr_err = err_q;
`else
   assign bad_req  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      w_en_d  = 1'b0;
      r_en_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && bad_req) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else if (req) begin
               state_d = ACCESS;
               cnt_d   = 4'd0;
               wr_d    = W_EN;
               addr_d  = word_idx;
               wdata_d = write_data;
               w_en_d  = W_EN;
               r_en_d  = ~W_EN;
            end
         end
         ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               if (!wr_q) rdata_d = sram_rdata;
            end else begin
               cnt_d  = cnt_q + 4'd1;
               w_en_d = wr_q;
               r_en_d = ~wr_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         w_en_q  <= 1'b0;
         r_en_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         w_en_q  <= w_en_d;
         r_en_q  <= r_en_d;
         err_q   <= err_d;
      end
   end

   assign ready      = (state_q == DONE) || ((state_q == IDLE) && !req);
   assign read_data  = rdata_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign sram_w_en  = w_en_q;
   assign sram_r_en  = r_en_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl against a transaction-level memory model
module tb_sram_ctrl;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        W_EN, R_EN;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [5:0]  sram_addr;
   logic        sram_w_en, sram_r_en;
   logic [31:0] sram_wdata, sram_rdata;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
   logic        addr_err;
`endif

   logic [31:0] sram_mem [64];
   logic [31:0] ref_mem  [64];
   logic [31:0] exp_read;
   int          cycle = 0;
   int          last_done;
   int          n_checks = 0;
   int          n_pass = 0;

   sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .W_EN       (W_EN),
      .R_EN       (R_EN),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_w_en  (sram_w_en),
      .sram_r_en  (sram_r_en),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      ,
      .addr_err   (addr_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (sram_w_en) sram_mem[sram_addr] <= sram_wdata;
   end

   assign sram_rdata = sram_mem[sram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One MEM-stage instruction: hold the request until ready, then release it at the DONE edge.
   task automatic txn(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
      logic [5:0] idx;
      bit         bad, got_ready, addr_ok, wd_ok, rd_seen, wr_seen;
      int         lows, strobes, t0;
      idx = 6'(((a - 32'd1024) >> 2) % 64);
      bad = 1'b0;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      bad = (a < 32'd1024) || (a >= 32'd1280) || (a % 4 != 0);
`endif
      W_EN = we; R_EN = re; address = a; write_data = d;
      t0 = cycle;
      got_ready = 0; addr_ok = 1; wd_ok = 1; rd_seen = 0; wr_seen = 0;
      lows = 0; strobes = 0;
      for (int k = 0; k < 40 && !got_ready; k++) begin
         @(negedge clk);
         if (sram_w_en || sram_r_en) begin
            strobes++;
            if (sram_addr !== idx) addr_ok = 0;
         end
         if (sram_w_en && sram_wdata !== d) wd_ok = 0;
         if (sram_r_en) rd_seen = 1;
         if (sram_w_en) wr_seen = 1;
         if (ready === 1'b1) got_ready = 1;
         else lows++;
      end
      last_done = cycle;
      if (!bad) begin
         if (we) ref_mem[idx] = d;
         else    exp_read = ref_mem[idx];
      end
      check({tag, " ready_seen"}, 32'(got_ready), 32'd1);
      check({tag, " freeze_len"}, lows, bad ? 1 : W + 1);
      check({tag, " done_cycle"}, last_done - t0, bad ? 1 : W + 1);
      check({tag, " strobe_cycles"}, strobes, bad ? 0 : W);
      check({tag, " addr_ok"}, 32'(addr_ok), 32'd1);
      check({tag, " wdata_ok"}, 32'(wd_ok), 32'd1);
      check({tag, " r_en_seen"}, 32'(rd_seen), 32'(!we && !bad));
      check({tag, " w_en_seen"}, 32'(wr_seen), 32'(we && !bad));
      check({tag, " read_data"}, read_data, exp_read);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      check({tag, " addr_err"}, 32'(addr_err), 32'(bad));
`endif
      @(posedge clk);
      #1;
      W_EN = 1'b0; R_EN = 1'b0;
   endtask

   initial begin
      int t_start;
      logic [31:0] a, d;
      logic        we, re;
      for (int i = 0; i < 64; i++) begin
         sram_mem[i] = $urandom;
         ref_mem[i]  = sram_mem[i];
      end
      exp_read = 32'd0;
      rst = 1'b1; W_EN = 1'b0; R_EN = 1'b0; address = 32'd0; write_data = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset read_data", read_data, 32'd0);
      check("reset sram_addr", 32'(sram_addr), 32'd0);
      check("reset sram_wdata", sram_wdata, 32'd0);
      check("reset strobes", {30'd0, sram_w_en, sram_r_en}, 32'd0);
      check("reset ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;

      txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, "store1028");
      txn(1'b0, 1'b1, 32'd1028, 32'h0, "load1028");
      repeat (3) @(negedge clk);
      check("load held", read_data, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      txn(1'b1, 1'b1, 32'd1032, 32'h12345678, "both_high");

      t_start = cycle;
      txn(1'b0, 1'b1, 32'd1024, 32'h0, "b2b_first");
      txn(1'b0, 1'b1, 32'd1276, 32'h0, "b2b_second");
      check("b2b total cycles", last_done - t_start + 1, 2 * (W + 2));

      // Reset during the second cycle of a load.
      W_EN = 1'b0; R_EN = 1'b1; address = 32'd1036;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; R_EN = 1'b0;
      @(negedge clk);
      exp_read = 32'd0;
      check("rst_mid strobes", {30'd0, sram_w_en, sram_r_en}, 32'd0);
      check("rst_mid read_data", read_data, 32'd0);
      check("rst_mid ready", 32'(ready), 32'(!(W_EN | R_EN)));
      @(posedge clk);
      #1;

      txn(1'b0, 1'b1, 32'd1000, 32'h0, "load1000");

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       a = 32'd1024 + ($urandom_range(0, 63) * 4);
            1:       a = 32'd1024 + $urandom_range(0, 255);
            2:       a = 32'd900 + $urandom_range(0, 600);
            default: a = 32'd1024 + ($urandom_range(0, 63) * 4);
         endcase
         d  = $urandom;
         we = 1'($urandom_range(0, 1));
         re = we ? 1'($urandom_range(0, 1)) : 1'b1;
         txn(we, re, a, d, "random");
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
